// File: rtl/apb_completer_pkg.sv
// Shared types and helpers for the APB completer register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_completer_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Byte address to word index; the two low bits select a byte lane.
  function automatic logic [APB_ADDR_W-3:0] word_idx(input logic [APB_ADDR_W-1:0] addr);
    return addr[APB_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/apb_completer_regbank.sv
// Register array with one write port and one read port, plus per-register write strobes.
// Latency: write lands on the enabling edge; wr_pulse_o follows one cycle later; read is combinational.
// Backpressure: none, a write enable is always accepted.
module apb_completer_regbank
  import apb_completer_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter int          IDX_W     = 3,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        we_i,
  input  logic [IDX_W-1:0]            idx_i,
  input  logic [APB_DATA_W-1:0]       wdata_i,
  input  logic [IDX_W-1:0]            rd_idx_i,
  output logic [APB_DATA_W-1:0]       rdata_o,
  output logic [32*NUM_REGS-1:0]      reg_q_o,
  output logic [NUM_REGS-1:0]         wr_pulse_o
);

  logic [APB_DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [NUM_REGS-1:0]   wr_pulse_d;

  // Register storage: the decoded index gates the write so out-of-range indices never touch the array.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we_i && (idx_i == IDX_W'(i))) regs_q[i] <= wdata_i;
      end
    end
  end

  // One-hot strobe for the register being written this cycle.
  always_comb begin
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_pulse_d[i] = we_i && (idx_i == IDX_W'(i));
    end
  end

  // Delay the strobe so it marks the cycle after the write commits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wr_pulse_q <= '0;
    else         wr_pulse_q <= wr_pulse_d;
  end

  // Read mux and flattened view of all registers.
  always_comb begin
    rdata_o = '0;
    reg_q_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q_o[32*i +: 32] = regs_q[i];
      if (rd_idx_i == IDX_W'(i)) rdata_o = regs_q[i];
    end
  end

  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/apb_completer_regfile.sv
// APB3 completer fronting NUM_REGS 32-bit registers with wait states and error responses.
// Latency: WAIT_STATES + 2 cycles per transfer (setup + WAIT_STATES+1 access cycles).
// Backpressure: PREADY held low for WAIT_STATES access cycles; aborts and protocol errors pulse prot_err.
module apb_completer_regfile
  import apb_completer_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [31:0]            PADDR,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [31:0]            PWDATA,
  output logic [31:0]            PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [32*NUM_REGS-1:0] reg_q,
  output logic [NUM_REGS-1:0]    wr_pulse,
  output logic                   prot_err
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  prot_err_q, prot_err_d;
  logic                  we;
  logic [APB_ADDR_W-3:0] widx;
  logic [APB_DATA_W-1:0] rdata;

  // State and latched-transfer registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      prot_err_q <= prot_err_d;
    end
  end

  // Next-state logic: setup latch, wait countdown, completion, abort detection.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    prot_err_d = 1'b0;
    we         = 1'b0;
    widx       = word_idx(PADDR);
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d   = widx[IDX_W-1:0];
          write_d = PWRITE;
          wdata_d = PWDATA;
          // Upper address bits are decoded in full, so high addresses never alias onto a register.
          err_d   = (PADDR[1:0] != 2'b00) || (widx >= (APB_ADDR_W-2)'(NUM_REGS));
          cnt_d   = 4'(WAIT_STATES);
          ready_d = (WAIT_STATES == 0);
          state_d = ACCESS;
        end else if (PSEL && PENABLE) begin
          // Access phase with no setup phase: flag it and ignore the transfer.
          prot_err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (!PSEL || !PENABLE) begin
          // Requester left the access phase before completion: drop the transfer.
          state_d    = IDLE;
          ready_d    = 1'b0;
          prot_err_d = 1'b1;
        end else if (ready_q) begin
          we      = write_q && !err_q;
          state_d = IDLE;
          ready_d = 1'b0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          ready_d = (cnt_q == 4'd1);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  apb_completer_regbank #(
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .RESET_VAL (RESET_VAL)
  ) u_regbank (
    .clk_i      (PCLK),
    .rst_ni     (PRESETn),
    .we_i       (we),
    .idx_i      (idx_q),
    .wdata_i    (wdata_q),
    .rd_idx_i   (idx_q),
    .rdata_o    (rdata),
    .reg_q_o    (reg_q),
    .wr_pulse_o (wr_pulse)
  );

  assign PREADY   = (state_q == ACCESS) && ready_q;
  assign PSLVERR  = err_q && PREADY;
  assign PRDATA   = (PREADY && !write_q && !err_q) ? rdata : '0;
  assign prot_err = prot_err_q;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Bench for apb_completer_regfile: three completers on one APB bus (WAIT_STATES 1, 0, 3).
// Table-driven transfers feed a scoreboard checked at PREADY; hand sequences cover aborts and reset.
module tb_apb_completer_regfile;

  localparam int NR = 8;
  localparam int WS_TAB [3] = '{1, 0, 3};

  logic           PCLK = 1'b0;
  logic           PRESETn = 1'b1;
  logic [31:0]    PADDR = '0;
  logic           PENABLE = 1'b0;
  logic           PWRITE = 1'b0;
  logic [31:0]    PWDATA = '0;
  logic [2:0]     psel = '0;
  logic [31:0]    prdata [3];
  logic           pready [3];
  logic           pslverr [3];
  logic [32*NR-1:0] regq [3];
  logic [NR-1:0]  wrp [3];
  logic           perr [3];

  always #5 PCLK = ~PCLK;

  apb_completer_regfile #(.NUM_REGS(NR), .WAIT_STATES(1), .RESET_VAL(32'h0)) u_ws1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(psel[0]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .reg_q(regq[0]), .wr_pulse(wrp[0]), .prot_err(perr[0]));
  apb_completer_regfile #(.NUM_REGS(NR), .WAIT_STATES(0), .RESET_VAL(32'h0)) u_ws0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(psel[1]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .reg_q(regq[1]), .wr_pulse(wrp[1]), .prot_err(perr[1]));
  apb_completer_regfile #(.NUM_REGS(NR), .WAIT_STATES(3), .RESET_VAL(32'h0)) u_ws3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(psel[2]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .reg_q(regq[2]), .wr_pulse(wrp[2]), .prot_err(perr[2]));

  typedef struct {
    int          k;
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          k;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    bit          idle_after;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mdl [3][NR];
  logic [NR-1:0] nxt_wrp [3] = '{default: '0};
  int          acc_cnt = 0;
  bit          mon_en = 1'b0;
  vec_t        tbl [16];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [32*NR-1:0] pack(input int k);
    logic [32*NR-1:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) r[32*i +: 32] = mdl[k][i];
    return r;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NR; i++) mdl[k][i] = 32'h0;
  endtask

  // Scoreboard: pop an expectation at every completion, check data, error, wait length and the strobe.
  always @(negedge PCLK) begin
    if (mon_en) begin
      if ((psel != 3'b000) && PENABLE) acc_cnt++;
      else acc_cnt = 0;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("wr_pulse%0d", k), 256'(wrp[k]), 256'(nxt_wrp[k]));
        nxt_wrp[k] = '0;
        if (psel[k] && PENABLE && pready[k]) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready inst=%0d", k);
          end else begin
            mon_e = sb_q.pop_front();
            chk($sformatf("ready_inst%0d", k), 256'(k), 256'(mon_e.k));
            chk($sformatf("prdata%0d", k), 256'(prdata[k]), 256'(mon_e.rdata));
            chk($sformatf("pslverr%0d", k), 256'(pslverr[k]), 256'(mon_e.err));
            chk($sformatf("access_cycles%0d", k), 256'(acc_cnt), 256'(WS_TAB[k] + 1));
            if (mon_e.wr && !mon_e.err) nxt_wrp[k] = NR'(1) << mon_e.idx;
          end
        end
      end
    end
  end

  // One full transfer; caller sits just after a rising edge. Bus is scrambled in the access phase.
  task automatic xfer(input int tag, input int k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input logic err,
                      input bit idle_after);
    exp_t e;
    int   n;
    e.k = k; e.wr = wr; e.idx = addr[4:2]; e.rdata = rd; e.err = err;
    psel = 3'(1 << k); PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    sb_q.push_back(e);
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PADDR = ~addr; PWDATA = ~wd; PWRITE = ~wr;
    n = 0;
    while (n < 40) begin
      @(negedge PCLK);
      if (pready[k]) break;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL ready_timeout vec=%0d actual=no_ready required=ready", tag);
    end
    @(posedge PCLK); #1;
    if (wr && !err) mdl[k][addr[4:2]] = wd;
    chk($sformatf("regq_vec%0d", tag), 256'(regq[k]), 256'(pack(k)));
    if (idle_after) begin
      psel = '0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //         k  wr    addr            wdata          rdata          err  idle
    tbl[0]  = '{0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1};
    tbl[1]  = '{0, 1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1};
    tbl[2]  = '{0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,         1'b1, 1'b1};
    tbl[3]  = '{0, 1'b0, 32'h0000_0005, 32'h0,         32'h0,         1'b1, 1'b1};
    tbl[4]  = '{0, 1'b1, 32'h4000_0008, 32'h0BAD_0BAD, 32'h0,         1'b1, 1'b1};
    tbl[5]  = '{0, 1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1};
    tbl[6]  = '{0, 1'b1, 32'h0000_001C, 32'hA5A5_0001, 32'h0,         1'b0, 1'b0};
    tbl[7]  = '{0, 1'b0, 32'h0000_001C, 32'h0,         32'hA5A5_0001, 1'b0, 1'b1};
    tbl[8]  = '{1, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0,         1'b0, 1'b0};
    tbl[9]  = '{1, 1'b1, 32'h0000_0004, 32'h2222_2222, 32'h0,         1'b0, 1'b0};
    tbl[10] = '{1, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0, 1'b0};
    tbl[11] = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'h2222_2222, 1'b0, 1'b1};
    tbl[12] = '{2, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b1};
    tbl[13] = '{2, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b1};
    tbl[14] = '{2, 1'b0, 32'h0000_0002, 32'h0,         32'h0,         1'b1, 1'b1};
    tbl[15] = '{0, 1'b0, 32'h0000_001E, 32'h0,         32'h0,         1'b1, 1'b1};
    clear_model();

    // Reset with an illegal access held on the bus: everything must stay quiet.
    #2 PRESETn = 1'b0;
    mon_en = 1'b1;
    psel = 3'b111; PENABLE = 1'b1; PWRITE = 1'b1; PWDATA = 32'hFFFF_FFFF;
    @(negedge PCLK); @(negedge PCLK);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_pready%0d", k), 256'(pready[k]), 256'(0));
      chk($sformatf("rst_pslverr%0d", k), 256'(pslverr[k]), 256'(0));
      chk($sformatf("rst_prdata%0d", k), 256'(prdata[k]), 256'(0));
      chk($sformatf("rst_regq%0d", k), 256'(regq[k]), 256'(0));
      chk($sformatf("rst_prot_err%0d", k), 256'(perr[k]), 256'(0));
    end
    @(posedge PCLK); #1;
    psel = '0; PENABLE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;

    for (int i = 0; i < 16; i++)
      xfer(i, tbl[i].k, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].err, tbl[i].idle_after);

    // PSEL dropped in the first access cycle of a WAIT_STATES=3 write.
    psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'hBBBB_0000;
    @(posedge PCLK); #1;
    psel = 3'b000; PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_prot_err", 256'(perr[2]), 256'(1));
    chk("abort_pready", 256'(pready[2]), 256'(0));
    @(negedge PCLK);
    chk("abort_prot_err_clear", 256'(perr[2]), 256'(0));
    chk("abort_regq", 256'(regq[2]), 256'(pack(2)));
    @(posedge PCLK); #1;
    xfer(20, 2, 1'b1, 32'h14, 32'hBBBB_0001, 32'h0, 1'b0, 1'b1);
    xfer(21, 2, 1'b0, 32'h14, 32'h0, 32'hBBBB_0001, 1'b0, 1'b1);

    // Access phase with no setup phase.
    psel = 3'b001; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hFFFF_FFFF;
    @(negedge PCLK);
    chk("nosetup_pready", 256'(pready[0]), 256'(0));
    @(posedge PCLK); #1;
    psel = '0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("nosetup_prot_err", 256'(perr[0]), 256'(1));
    chk("nosetup_pready_after", 256'(pready[0]), 256'(0));
    @(negedge PCLK);
    chk("nosetup_prot_err_clear", 256'(perr[0]), 256'(0));
    chk("nosetup_regq", 256'(regq[0]), 256'(pack(0)));

    // PENABLE stays low while in the access phase.
    @(posedge PCLK); #1;
    psel = 3'b001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h18; PWDATA = 32'h7777_7777;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    psel = '0;
    @(negedge PCLK);
    chk("penlow_prot_err", 256'(perr[0]), 256'(1));
    @(negedge PCLK);
    chk("penlow_prot_err_clear", 256'(perr[0]), 256'(0));
    chk("penlow_regq", 256'(regq[0]), 256'(pack(0)));

    // Reset during the wait state of a write to 0x0C.
    @(posedge PCLK); #1;
    psel = 3'b001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'h3333_3333;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("midrst_wait_pready", 256'(pready[0]), 256'(0));
    #1 PRESETn = 1'b0;
    clear_model();
    #1;
    chk("midrst_pready", 256'(pready[0]), 256'(0));
    chk("midrst_pslverr", 256'(pslverr[0]), 256'(0));
    chk("midrst_prdata", 256'(prdata[0]), 256'(0));
    @(negedge PCLK);
    for (int k = 0; k < 3; k++)
      chk($sformatf("midrst_regq%0d", k), 256'(regq[k]), 256'(pack(k)));
    @(posedge PCLK); #1;
    psel = '0; PENABLE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(30, 0, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 1'b1);
    xfer(31, 0, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 1'b1);

    @(negedge PCLK);
    chk("scoreboard_empty", 256'(sb_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
